sized_data_memory: RTL and testbench
====================================

# sized_data_memory

Parametrised byte-addressable data memory for the datapath's load/store stage. It supports byte, halfword and word access with sign or zero extension and has a valid/ready request port. The read pipeline depth is configurable. After reset it runs a word-by-word clearing sweep and flags misaligned or out-of-range accesses instead of executing them.

## Interface
- DEPTH, 32: number of 32-bit words; 2..1024, need not be a power of two.
- ADDR_WIDTH, 7: byte-address width; must satisfy 2^ADDR_WIDTH >= 4*DEPTH.
- READ_LATENCY, 1: cycles from request acceptance to rsp_valid; 1..4.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_error  out  1  request was misaligned, out of range or had an illegal size.

## Operation
- Two states: CLEAR and IDLE.
- Reset asserted: state = CLEAR, clear counter = 0, response pipeline flushed. Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0.
- CLEAR: one word is zeroed per cycle at the counter index. After word DEPTH-1 is written, the next state is IDLE. req_ready=0 throughout.
- IDLE: req_ready=1. A request is accepted when req_valid && req_ready.
- Word index = req_addr[ADDR_WIDTH-1:2]; lane = req_addr[1:0].
- Error conditions, any of:
  - req_size=11
  - half with lane[0]=1
  - word with lane!=00
  - word index >= DEPTH
- On error, memory is unchanged, rsp_error=1 and rsp_rdata=0.
- Stores:
  - byte writes lane byte from wdata[7:0].
  - half writes bytes lane and lane+1 from wdata[15:0].
  - word writes all four bytes.
  - Unaddressed bytes are preserved. Little-endian: byte 0 = bits [7:0].
- Loads: the selected byte/half is shifted to bit 0, then sign- or zero-extended to 32 bits. req_unsigned is ignored for word loads.
- Every accepted request, store or load, produces exactly one response. Responses return in request order. There is no response backpressure.
- Read data is captured at acceptance and carried down the pipeline, so later stores cannot alter an in-flight response.

## Timing
- Reset release to first req_ready=1: exactly DEPTH rising edges.
- Request accepted at edge N → rsp_valid high during the cycle after edge N+READ_LATENCY-1; latency 1 means valid in the cycle after acceptance.
- Throughput: one request per cycle. Back-to-back requests give back-to-back rsp_valid pulses.
- rsp_rdata and rsp_error are valid only while rsp_valid=1. Otherwise they hold 0.
- Store accepted at edge N is visible to a load accepted at edge N+1 (read-after-write, no bypass stall).
- Reset mid-operation: in-flight responses are discarded, never emitted, and the clear sweep restarts from word 0.
- A request presented while req_ready=0 is ignored and gives no response.

## Test plan
- Reset/clear: DEPTH=32, release reset_n → req_ready rises after exactly 32 cycles. A load of word at address 0x7C then returns rsp_rdata=0x00000000, rsp_error=0.
- Byte/half stores with extension:
  - store word 0xAABBCCDD at 0x10, then store byte 0x80 at 0x11.
  - signed byte load at 0x11 → 0xFFFFFF80.
  - unsigned half load at 0x12 → 0x0000AABB.
  - word load at 0x10 → 0xAABB80DD.
- Errors: half load at 0x03, word store at 0x06, size=11 at 0x00, and word access at 0x80 with DEPTH=32 → each gives rsp_error=1, rsp_rdata=0, and memory is unchanged (verify by reloading).
- Latency: READ_LATENCY=3, four back-to-back loads → four consecutive rsp_valid pulses, starting 3 cycles after the first acceptance, in order.
- Read-after-write: store 0x12345678 at 0x20, load at 0x20 on the next cycle → 0x12345678.
- Mid-operation reset: assert reset_n=0 with two loads in flight → no rsp_valid is emitted, and req_ready=0 for DEPTH cycles after release.

Source files
------------

// File: rtl/sized_data_memory_if.sv
// Load/store request and response port of sized_data_memory.
// The memory side uses the slave modport; the requester uses master.
interface sized_data_memory_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/sized_data_memory.sv
// Byte-addressable data memory with byte/half/word access and a fixed-latency
// response pipeline. It zeroes itself word by word after reset.
module sized_data_memory #(
    parameter int DEPTH        = 32,
    parameter int ADDR_WIDTH   = 7,
    parameter int READ_LATENCY = 1
) (
    input logic           clk,
    input logic           reset_n,
    sized_data_memory_if.slave bus
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clr_cnt_q;
    logic             clr_last;
    logic             ready;

    logic [31:0] mem [DEPTH];

    assign clr_last = (clr_cnt_q == CNT_W'(DEPTH - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; combinational blocks use blocking with defaults first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR && !clr_last) clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            CLEAR: if (clr_last) state_d = IDLE;
            IDLE:  ready = 1'b1;
            default: state_d = CLEAR;
        endcase
    end

    assign bus.req_ready = ready;

    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             in_range;
    logic             error;
    logic [CNT_W-1:0] mem_idx;

    assign accept   = bus.req_valid && ready;
    assign word_idx = bus.req_addr[ADDR_WIDTH-1:2];
    assign lane     = bus.req_addr[1:0];
    assign in_range = ({1'b0, word_idx} < DEPTH_L);
    assign error    = (bus.req_size == 2'b11)
                   || (bus.req_size == 2'b01 && lane[0])
                   || (bus.req_size == 2'b10 && lane != 2'b00)
                   || !in_range;
    assign mem_idx  = in_range ? word_idx[CNT_W-1:0] : '0;

    logic [31:0] rd_word;
    logic [15:0] rd_sh;
    logic [31:0] rd_ext;
    logic [31:0] rsp_data_d;

    assign rd_word = mem[mem_idx];
    assign rd_sh   = 16'(rd_word >> {lane, 3'b000});

    always_comb begin
        rd_ext = rd_word;
        case (bus.req_size)
            2'b00: rd_ext = bus.req_unsigned ? {24'd0, rd_sh[7:0]}
                                             : {{24{rd_sh[7]}}, rd_sh[7:0]};
            2'b01: rd_ext = bus.req_unsigned ? {16'd0, rd_sh}
                                             : {{16{rd_sh[15]}}, rd_sh};
            default: rd_ext = rd_word;
        endcase
    end

    assign rsp_data_d = (!error && !bus.req_write) ? rd_ext : 32'd0;

    logic [3:0]  byte_en;
    logic [31:0] wdata_sh;
    logic        do_write;

    always_comb begin
        byte_en = 4'b1111;
        case (bus.req_size)
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = 4'b0011 << lane;
            default: byte_en = 4'b1111;
        endcase
    end

    assign wdata_sh = bus.req_wdata << {lane, 3'b000};
    assign do_write = accept && bus.req_write && !error;

    // NOTE: the storage array has no reset; the clearing sweep zeroes it, which
    // keeps it mappable onto RAM.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[mem_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    // Response data is captured at acceptance, so later stores cannot change it.
    logic [READ_LATENCY-1:0]       pipe_valid;
    logic [READ_LATENCY-1:0]       pipe_err;
    logic [READ_LATENCY-1:0][31:0] pipe_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            pipe_data  <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && error;
            pipe_data[0]  <= accept ? rsp_data_d : 32'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign bus.rsp_valid = pipe_valid[READ_LATENCY-1];
    assign bus.rsp_error = pipe_err[READ_LATENCY-1];
    assign bus.rsp_rdata = pipe_data[READ_LATENCY-1];
endmodule

// File: tb/tb_sized_data_memory.sv
// Self-checking bench: one stimulus stream drives a latency-1 and a latency-3
// instance; each has its own scoreboard queue checked on the falling edge.
module tb_sized_data_memory;
    localparam int DEPTH = 32;
    localparam int AW    = 8;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;
    bit   mon_en;

    sized_data_memory_if #(.ADDR_WIDTH(AW)) bus1 ();
    sized_data_memory_if #(.ADDR_WIDTH(AW)) bus3 ();

    assign bus3.req_valid    = bus1.req_valid;
    assign bus3.req_write    = bus1.req_write;
    assign bus3.req_size     = bus1.req_size;
    assign bus3.req_unsigned = bus1.req_unsigned;
    assign bus3.req_addr     = bus1.req_addr;
    assign bus3.req_wdata    = bus1.req_wdata;

    sized_data_memory #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );
    sized_data_memory #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [7:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_data, input logic exp_err);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    // Drive one request for a cycle; queue its expectation only if it will be accepted.
    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus1.req_valid    = 1'b1;
        bus1.req_write    = v.wr;
        bus1.req_size     = v.size;
        bus1.req_unsigned = v.uns;
        bus1.req_addr     = v.addr;
        bus1.req_wdata    = v.wdata;
        if (bus1.req_ready) begin
            e.data = v.exp_data;
            e.err  = v.exp_err;
            e.due  = cyc + 1;
            q1.push_back(e);
            e.due  = cyc + 3;
            q3.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus1.req_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!bus1.req_ready && k < 4 * DEPTH) begin
            @(negedge clk);
            k++;
        end
        bus1.req_valid = 1'b0;
        check(name, 32'(k), 32'(DEPTH));
        check({name, " lat3 ready"}, 32'(bus3.req_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus1.rsp_valid) begin
                if (q1.size() == 0) begin
                    check("lat1 unexpected rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("lat1 rdata", bus1.rsp_rdata, e.data);
                    check("lat1 error", 32'(bus1.rsp_error), 32'(e.err));
                    check("lat1 cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                check("lat1 idle outputs", bus1.rsp_rdata | 32'(bus1.rsp_error), 32'd0);
                if (q1.size() > 0 && q1[0].due <= cyc) begin
                    check("lat1 missing rsp", 32'(cyc), 32'(q1[0].due));
                    void'(q1.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus3.rsp_valid) begin
                if (q3.size() == 0) begin
                    check("lat3 unexpected rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q3.pop_front();
                    check("lat3 rdata", bus3.rsp_rdata, e.data);
                    check("lat3 error", 32'(bus3.rsp_error), 32'(e.err));
                    check("lat3 cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                check("lat3 idle outputs", bus3.rsp_rdata | 32'(bus3.rsp_error), 32'd0);
                if (q3.size() > 0 && q3[0].due <= cyc) begin
                    check("lat3 missing rsp", 32'(cyc), 32'(q3[0].due));
                    void'(q3.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;

        // Expected values worked out by hand from little-endian byte layout.
        vecs.push_back(mk(0, 2'b10, 0, 8'h7C, 32'h0,        32'h00000000, 0));
        vecs.push_back(mk(1, 2'b10, 0, 8'h10, 32'hAABBCCDD, 32'h00000000, 0));
        vecs.push_back(mk(1, 2'b00, 0, 8'h11, 32'h00000080, 32'h00000000, 0));
        vecs.push_back(mk(0, 2'b00, 0, 8'h11, 32'h0,        32'hFFFFFF80, 0));
        vecs.push_back(mk(0, 2'b01, 1, 8'h12, 32'h0,        32'h0000AABB, 0));
        vecs.push_back(mk(0, 2'b10, 0, 8'h10, 32'h0,        32'hAABB80DD, 0));
        vecs.push_back(mk(0, 2'b01, 0, 8'h03, 32'h0,        32'h00000000, 1));
        vecs.push_back(mk(1, 2'b10, 0, 8'h06, 32'hDEADBEEF, 32'h00000000, 1));
        vecs.push_back(mk(1, 2'b11, 0, 8'h00, 32'hFFFFFFFF, 32'h00000000, 1));
        vecs.push_back(mk(0, 2'b10, 0, 8'h80, 32'h0,        32'h00000000, 1));
        vecs.push_back(mk(1, 2'b10, 0, 8'h80, 32'hCAFEF00D, 32'h00000000, 1));
        vecs.push_back(mk(0, 2'b00, 1, 8'hFF, 32'h0,        32'h00000000, 1));
        vecs.push_back(mk(0, 2'b10, 0, 8'h04, 32'h0,        32'h00000000, 0));
        vecs.push_back(mk(0, 2'b10, 0, 8'h00, 32'h0,        32'h00000000, 0));
        vecs.push_back(mk(0, 2'b11, 0, 8'h10, 32'h0,        32'h00000000, 1));
        vecs.push_back(mk(0, 2'b10, 0, 8'h10, 32'h0,        32'hAABB80DD, 0));
        vecs.push_back(mk(1, 2'b10, 0, 8'h20, 32'h12345678, 32'h00000000, 0));
        vecs.push_back(mk(0, 2'b10, 0, 8'h20, 32'h0,        32'h12345678, 0));
        vecs.push_back(mk(0, 2'b00, 0, 8'h13, 32'h0,        32'hFFFFFFAA, 0));
        vecs.push_back(mk(0, 2'b00, 1, 8'h13, 32'h0,        32'h000000AA, 0));
        vecs.push_back(mk(0, 2'b01, 0, 8'h12, 32'h0,        32'hFFFFAABB, 0));
        vecs.push_back(mk(0, 2'b01, 0, 8'h20, 32'h0,        32'h00005678, 0));
        vecs.push_back(mk(1, 2'b01, 0, 8'h22, 32'hFFFF9876, 32'h00000000, 0));
        vecs.push_back(mk(0, 2'b10, 0, 8'h20, 32'h0,        32'h98765678, 0));
        vecs.push_back(mk(0, 2'b10, 1, 8'h20, 32'h0,        32'h98765678, 0));
        vecs.push_back(mk(0, 2'b00, 1, 8'h23, 32'h0,        32'h00000098, 0));
        vecs.push_back(mk(0, 2'b00, 0, 8'h22, 32'h0,        32'h00000076, 0));
        vecs.push_back(mk(0, 2'b01, 0, 8'h21, 32'h0,        32'h00000000, 1));
        vecs.push_back(mk(0, 2'b10, 0, 8'h20, 32'h0,        32'h98765678, 0));
        vecs.push_back(mk(1, 2'b10, 0, 8'h20, 32'h11111111, 32'h00000000, 0));
        vecs.push_back(mk(0, 2'b10, 0, 8'h20, 32'h0,        32'h11111111, 0));
        vecs.push_back(mk(1, 2'b00, 0, 8'h7F, 32'h0000005A, 32'h00000000, 0));
        vecs.push_back(mk(0, 2'b10, 0, 8'h7C, 32'h0,        32'h5A000000, 0));

        reset_n           = 1'b0;
        bus1.req_valid    = 1'b0;
        bus1.req_write    = 1'b0;
        bus1.req_size     = 2'b10;
        bus1.req_unsigned = 1'b0;
        bus1.req_addr     = '0;
        bus1.req_wdata    = '0;
        repeat (3) @(negedge clk);

        check("reset req_ready", 32'(bus1.req_ready), 32'd0);
        check("reset rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        check("reset rsp_rdata", bus1.rsp_rdata, 32'd0);
        check("reset rsp_error", 32'(bus1.rsp_error), 32'd0);
        check("reset lat3 rsp_valid", 32'(bus3.rsp_valid), 32'd0);
        mon_en = 1'b1;

        // A store offered during the sweep must be ignored.
        bus1.req_valid = 1'b1;
        bus1.req_write = 1'b1;
        bus1.req_addr  = 8'h7C;
        bus1.req_wdata = 32'hFFFFFFFF;
        reset_n = 1'b1;
        wait_ready("clear sweep length");

        // Back-to-back table application.
        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
        idle();

        // Sparse requests with gaps.
        drive(mk(0, 2'b10, 0, 8'h10, 32'h0, 32'hAABB80DD, 0));
        idle();
        idle();
        drive(mk(0, 2'b01, 1, 8'h10, 32'h0, 32'h000080DD, 0));
        idle();
        repeat (5) @(negedge clk);

        // Mid-operation reset with two loads in flight.
        drive(mk(0, 2'b10, 0, 8'h10, 32'h0, 32'hAABB80DD, 0));
        drive(mk(0, 2'b10, 0, 8'h20, 32'h0, 32'h11111111, 0));
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        bus1.req_valid = 1'b0;
        q1.delete();
        q3.delete();
        repeat (3) begin
            @(negedge clk);
            check("in-reset lat1 rsp_valid", 32'(bus1.rsp_valid), 32'd0);
            check("in-reset lat3 rsp_valid", 32'(bus3.rsp_valid), 32'd0);
        end
        reset_n = 1'b1;
        wait_ready("re-clear sweep length");

        // Sweep must have restarted and zeroed previously written words.
        drive(mk(0, 2'b10, 0, 8'h10, 32'h0, 32'h00000000, 0));
        drive(mk(0, 2'b10, 0, 8'h7C, 32'h0, 32'h00000000, 0));
        idle();

        for (int k = 0; k < 20 && (q1.size() + q3.size()) > 0; k++) @(negedge clk);
        check("scoreboard drained", 32'(q1.size() + q3.size()), 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
